// File: rtl/spi_txn_monitor_pkg.sv
// Purpose: shared command codes, phase lengths and FSM state encoding for the SPI transaction monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_txn_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    SKIP
  } state_t;

endpackage

// File: rtl/spi_txn_shadow_mem.sv
// Purpose: 16 x 32 shadow of written data; checks each captured read against the last write to that slot.
// Latency: mismatch is combinational with rd_valid; err_count updates one clk later.
// Backpressure: none, every record is consumed in the cycle it is presented.
module spi_txn_shadow_mem #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_valid,
  input  logic [3:0]       wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             rd_valid,
  input  logic [3:0]       rd_idx,
  input  logic [31:0]      rd_data,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0]      r_mem [16];
  logic [15:0]      r_written;
  logic [CNT_W-1:0] r_err_count;
  logic             w_mismatch;

  // Reads of slots never written carry no expectation, so they never flag.
  assign w_mismatch = rd_valid & r_written[rd_idx] & (r_mem[rd_idx] != rd_data);
  assign mismatch   = w_mismatch;
  assign err_count  = r_err_count;

  // Shadow update on writes, error tally on failed compares.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_written   <= '0;
      r_err_count <= '0;
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else begin
      if (wr_valid) begin
        r_mem[wr_idx]     <= wr_data;
        r_written[wr_idx] <= 1'b1;
      end
      if (w_mismatch) r_err_count <= r_err_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_txn_monitor.sv
// Purpose: passive SPI write-mem/read-mem decoder producing address/data records; optional scoreboard via SPI_TXN_MONITOR_SCOREBOARD_EN.
// Latency: valid/cmd_err/abort pulse 1 clk after the SCLK rise (or CS rise) that ends the phase.
// Backpressure: none, purely observational; records are single-cycle pulses that must be taken when seen.
module spi_txn_monitor
  import spi_txn_pkg::*;
#(
  parameter int DUMMY_CYCLES = 32,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             spi_sclk,
  input  logic             spi_cs,
  input  logic             spi_sdo,
  input  logic             spi_sdi,
  output logic             wr_valid,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             rd_valid,
  output logic [31:0]      rd_addr,
  output logic [31:0]      rd_data,
  output logic             cmd_err,
  output logic             abort,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count
`ifdef SPI_TXN_MONITOR_SCOREBOARD_EN
  ,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count
`endif
);

  localparam logic [5:0] LD_CMD   = 6'(CMD_BITS - 1);
  localparam logic [5:0] LD_ADDR  = 6'(ADDR_BITS - 1);
  localparam logic [5:0] LD_DATA  = 6'(DATA_BITS - 1);
  localparam logic [5:0] LD_DUMMY = 6'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

  state_t           r_state, w_state_nxt;
  logic [5:0]       r_bitcnt, w_bitcnt_nxt;
  logic             r_sclk_q, r_is_read;
  logic [31:0]      r_shift, r_addr;
  logic             r_wr_valid, r_rd_valid, r_cmd_err, r_abort;
  logic [31:0]      r_wr_addr, r_wr_data, r_rd_addr, r_rd_data;
  logic [CNT_W-1:0] r_wr_count, r_rd_count;

  logic        w_rise, w_bit, w_last;
  logic [31:0] w_shift_nxt;
  logic        w_cmd_ok, w_cmd_err, w_addr_load, w_done, w_abort;

  // A CS-gated SCLK rise is the only sampling event; read data comes from MISO.
  assign w_rise      = spi_sclk & ~r_sclk_q & ~spi_cs;
  assign w_bit       = (r_state == DATA && r_is_read) ? spi_sdi : spi_sdo;
  assign w_shift_nxt = {r_shift[30:0], w_bit};
  assign w_last      = w_rise && (r_bitcnt == 6'd0);

  // State and bit counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
    end
  end

  // Phase sequencing; CS high in an active phase ends it, and counts as an abort
  // unless we are sitting at a clean command boundary.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_cmd_ok     = 1'b0;
    w_cmd_err    = 1'b0;
    w_addr_load  = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!spi_cs) begin
          w_state_nxt  = CMD;
          w_bitcnt_nxt = LD_CMD;
        end
      end
      CMD, ADDR, DUMMY, DATA: begin
        if (spi_cs) begin
          w_state_nxt = IDLE;
          w_abort     = (r_state != CMD) || (r_bitcnt != LD_CMD);
        end else if (w_rise) begin
          w_bitcnt_nxt = r_bitcnt - 6'd1;
          if (w_last) begin
            case (r_state)
              CMD: begin
                if (w_shift_nxt[7:0] == CMD_WRITE || w_shift_nxt[7:0] == CMD_READ) begin
                  w_cmd_ok     = 1'b1;
                  w_state_nxt  = ADDR;
                  w_bitcnt_nxt = LD_ADDR;
                end else begin
                  w_cmd_err   = 1'b1;
                  w_state_nxt = SKIP;
                end
              end
              ADDR: begin
                w_addr_load = 1'b1;
                if (r_is_read && DUMMY_CYCLES > 0) begin
                  w_state_nxt  = DUMMY;
                  w_bitcnt_nxt = LD_DUMMY;
                end else begin
                  w_state_nxt  = DATA;
                  w_bitcnt_nxt = LD_DATA;
                end
              end
              DUMMY: begin
                w_state_nxt  = DATA;
                w_bitcnt_nxt = LD_DATA;
              end
              default: begin
                w_done       = 1'b1;
                w_state_nxt  = CMD;
                w_bitcnt_nxt = LD_CMD;
              end
            endcase
          end
        end
      end
      SKIP: begin
        if (spi_cs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift path, captured fields, output records, pulses and counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sclk_q   <= 1'b0;
      r_shift    <= '0;
      r_is_read  <= 1'b0;
      r_addr     <= '0;
      r_wr_valid <= 1'b0;
      r_rd_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_abort    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_addr  <= '0;
      r_rd_data  <= '0;
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      r_sclk_q   <= spi_sclk;
      r_wr_valid <= w_done & ~r_is_read;
      r_rd_valid <= w_done & r_is_read;
      r_cmd_err  <= w_cmd_err;
      r_abort    <= w_abort;
      if (w_rise)      r_shift   <= w_shift_nxt;
      if (w_cmd_ok)    r_is_read <= (w_shift_nxt[7:0] == CMD_READ);
      if (w_addr_load) r_addr    <= w_shift_nxt;
      if (w_done && !r_is_read) begin
        r_wr_addr  <= r_addr;
        r_wr_data  <= w_shift_nxt;
        r_wr_count <= r_wr_count + CNT_W'(1);
      end
      if (w_done && r_is_read) begin
        r_rd_addr  <= r_addr;
        r_rd_data  <= w_shift_nxt;
        r_rd_count <= r_rd_count + CNT_W'(1);
      end
    end
  end

  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_valid = r_rd_valid;
  assign rd_addr  = r_rd_addr;
  assign rd_data  = r_rd_data;
  assign cmd_err  = r_cmd_err;
  assign abort    = r_abort;
  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;

`ifdef SPI_TXN_MONITOR_SCOREBOARD_EN
  spi_txn_shadow_mem #(.CNT_W(CNT_W)) u_shadow (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_valid  (r_wr_valid),
    .wr_idx    (r_wr_addr[5:2]),
    .wr_data   (r_wr_data),
    .rd_valid  (r_rd_valid),
    .rd_idx    (r_rd_addr[5:2]),
    .rd_data   (r_rd_data),
    .mismatch  (mismatch),
    .err_count (err_count)
  );
`endif

endmodule
